// File: rtl/dcache_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dcache_pkg
// Purpose : Shared types, geometry constants and the word-select helper for
//           the direct-mapped write-through L1 data cache.
// Contents: state_t      - controller FSM states (IDLE / FILL / WTHRU)
//           WORD_W       - CPU word width
//           LINE_W       - cache line width (4 words)
//           ADDR_W       - word address width
//           INDEX_BITS   - line index bits
//           OFFSET_BITS  - word-in-line offset bits
//           TAG_W        - tag width
//           word_sel()   - extract word k from a line
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package dcache_pkg;

  localparam int WORD_W      = 32;
  localparam int LINE_W      = 128;
  localparam int ADDR_W      = 10;
  localparam int INDEX_BITS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_W       = ADDR_W - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WTHRU = 2'd2
  } state_t;

  // Word k of a line lives at bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] word_sel(
    input logic [LINE_W-1:0]      line,
    input logic [OFFSET_BITS-1:0] off
  );
    return line[WORD_W*int'(off) +: WORD_W];
  endfunction

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_line_array.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dcache_line_array
// Purpose : Valid / tag / data storage for the direct-mapped data cache.
//           Only the valid bits are reset (asynchronously); tag and data
//           contents are meaningless until their valid bit is set.
// Ports   : clk, reset        - clock, async active-high reset
//           wr_idx            - line index shared by both write ports
//           line_we/line_tag/line_data - full line fill, sets valid
//           word_we/word_off/word_data - single word update (write hit)
//           rd_idx            - combinational read index
//           rd_valid/rd_tag/rd_line    - combinational read data
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINE_WIDTH  = 128,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 4,
  parameter int TAG_WIDTH   = 4,
  parameter int OFF_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  line_we,
  input  logic [TAG_WIDTH-1:0]  line_tag,
  input  logic [LINE_WIDTH-1:0] line_data,
  input  logic                  word_we,
  input  logic [OFF_BITS-1:0]   word_off,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [LINE_WIDTH-1:0] rd_line
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [TAG_WIDTH-1:0]  r_tag  [LINES];
  logic [LINE_WIDTH-1:0] r_data [LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (line_we) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

  // A fill and a word update are never requested in the same cycle; the
  // fill takes precedence should that ever happen.
  always_ff @(posedge clk) begin
    if (line_we) begin
      r_tag[wr_idx]  <= line_tag;
      r_data[wr_idx] <= line_data;
    end else if (word_we) begin
      r_data[wr_idx][DATA_WIDTH*int'(word_off) +: DATA_WIDTH] <= word_data;
    end
  end

  assign rd_valid = r_valid[rd_idx];
  assign rd_tag   = r_tag[rd_idx];
  assign rd_line  = r_data[rd_idx];

endmodule : dcache_line_array
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : dcache_controller
// Purpose : Direct-mapped, write-through, no-write-allocate L1 data cache
//           between the CPU load/store port and data_memory. Read hits
//           complete with no wait; misses fill a 128-bit line, and every
//           store is written through as a single word. The CPU is stalled
//           until mem_ready on misses and stores.
// Ports   : clk, reset              - clock, async active-high reset
//           cpu_read/cpu_write      - CPU requests (held while stalled)
//           cpu_addr/cpu_wdata      - CPU word address / store data
//           cpu_rdata/cpu_stall     - load data / stall back to CPU
//           mem_read/mem_write      - line fill / word write-through request
//           mem_addr/mem_wdata      - memory address / write data
//           mem_line/mem_ready      - fill data / completion pulse
//           hit_count/miss_count    - saturating read hit/miss statistics
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_line,
  input  logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  // Address fields of the live CPU request and of the latched request.
  logic [TAG_WIDTH-1:0]   w_cpu_tag;
  logic [INDEX_BITS-1:0]  w_cpu_idx;
  logic [OFFSET_BITS-1:0] w_cpu_off;
  logic [TAG_WIDTH-1:0]   w_lat_tag;
  logic [INDEX_BITS-1:0]  w_lat_idx;
  logic [OFFSET_BITS-1:0] w_lat_off;

  assign {w_cpu_tag, w_cpu_idx, w_cpu_off} = cpu_addr;
  assign {w_lat_tag, w_lat_idx, w_lat_off} = r_addr;

  logic                  w_rd_valid;
  logic [TAG_WIDTH-1:0]  w_rd_tag;
  logic [LINE_WIDTH-1:0] w_rd_line;
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [TAG_WIDTH-1:0]  w_cmp_tag;
  logic                  w_hit;

  logic w_line_we;
  logic w_word_we;
  logic w_hit_inc;
  logic w_miss_inc;

  // In IDLE the array is probed with the live request; in WTHRU the latched
  // address decides whether the resident line needs its word updated.
  assign w_rd_idx  = (r_state == IDLE) ? w_cpu_idx : w_lat_idx;
  assign w_cmp_tag = (r_state == IDLE) ? w_cpu_tag : w_lat_tag;
  assign w_hit     = w_rd_valid && (w_rd_tag == w_cmp_tag);

  dcache_line_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .TAG_WIDTH  (TAG_WIDTH),
    .OFF_BITS   (OFFSET_BITS)
  ) u_lines (
    .clk       (clk),
    .reset     (reset),
    .wr_idx    (w_lat_idx),
    .line_we   (w_line_we),
    .line_tag  (w_lat_tag),
    .line_data (mem_line),
    .word_we   (w_word_we),
    .word_off  (w_lat_off),
    .word_data (r_wdata),
    .rd_idx    (w_rd_idx),
    .rd_valid  (w_rd_valid),
    .rd_tag    (w_rd_tag),
    .rd_line   (w_rd_line)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The request is captured every IDLE cycle, so the copy taken on the cycle
  // that leaves IDLE is the one used for the whole transaction; address
  // changes while stalled are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE) begin
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
    end
  end

  always_comb begin
    w_next     = r_state;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    w_line_we  = 1'b0;
    w_word_we  = 1'b0;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;

    case (r_state)
      IDLE: begin
        if (cpu_write) begin
          cpu_stall = 1'b1;
          w_next    = WTHRU;
        end else if (cpu_read) begin
          if (w_hit) begin
            cpu_rdata = word_sel(w_rd_line, w_cpu_off);
            w_hit_inc = 1'b1;
          end else begin
            cpu_stall  = 1'b1;
            w_miss_inc = 1'b1;
            w_next     = FILL;
          end
        end
      end

      FILL: begin
        mem_read  = 1'b1;
        mem_addr  = {w_lat_tag, w_lat_idx, {OFFSET_BITS{1'b0}}};
        cpu_stall = 1'b1;
        if (mem_ready) begin
          // Forward the requested word straight from the fill bus.
          cpu_rdata = word_sel(mem_line, w_lat_off);
          cpu_stall = 1'b0;
          w_line_we = 1'b1;
          w_next    = IDLE;
        end
      end

      WTHRU: begin
        mem_write = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        cpu_stall = 1'b1;
        if (mem_ready) begin
          cpu_stall = 1'b0;
          w_word_we = w_hit;
          w_next    = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_inc && (hit_count != {CNT_WIDTH{1'b1}})) begin
        hit_count <= hit_count + 1'b1;
      end
      if (w_miss_inc && (miss_count != {CNT_WIDTH{1'b1}})) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end

endmodule : dcache_controller
`default_nettype wire
